// File: rtl/rk4_k_sequencer_pkg.sv
// Shared definitions for the RK4 slope sequencer.
// Holds the default data/fraction widths, the FSM state encoding and the
// Q16.16 constants ONE and HALF.
package rk4_k_sequencer_pkg;

  localparam int N_DEF    = 32;
  localparam int FRAC_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;

endpackage

// File: rtl/rk4_k_sequencer_if.sv
// Request/acknowledge bus between the sequencer and the derivative unit f(t,y).
// master: F_REQ/F_T/F_Y out, F_ACK/F_VAL in. slave: the mirror image.
// F_T/F_Y are held stable while F_REQ=1; F_VAL is taken on F_REQ && F_ACK.
interface rk4_k_sequencer_if #(
  parameter int N = 32
) ();

  logic         F_REQ;
  logic [N-1:0] F_T;
  logic [N-1:0] F_Y;
  logic         F_ACK;
  logic [N-1:0] F_VAL;

  modport master (
    output F_REQ, F_T, F_Y,
    input  F_ACK, F_VAL
  );

  modport slave (
    input  F_REQ, F_T, F_Y,
    output F_ACK, F_VAL
  );

endinterface

// File: rtl/rk4_k_sequencer_fx_mul_q.sv
// Signed fixed-point multiply: full 2N-bit product, keep bits [N+FRAC-1:FRAC].
// Latency: combinational. Backpressure: none.
// Ports: a_i, b_i operands; p_o result (floor rounding, wraps on overflow).
module rk4_k_sequencer_fx_mul_q #(
  parameter int N    = 32,
  parameter int FRAC = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  logic [2*N-1:0] prod_full;
  logic           unused_prod;

  // Sign-extend both operands to 2N so the low 2N bits of the product are exact.
  assign prod_full = $signed({{N{a_i[N-1]}}, a_i}) * $signed({{N{b_i[N-1]}}, b_i});

  // Dropping the low FRAC bits of a two's-complement value rounds toward -inf.
  assign p_o = prod_full[N+FRAC-1:FRAC];

  // High bits are discarded on purpose: overflow wraps.
  assign unused_prod = ^{prod_full[2*N-1:N+FRAC], prod_full[FRAC-1:0]};

endmodule

// File: rtl/rk4_k_sequencer.sv
// Produces the RK4 slopes K_1..K_4 by calling f(t,y) four times and scaling by h.
// Latency: START -> K_VALID is 9 cycles plus one per cycle F_ACK is late.
// Backpressure: F_REQ is held until F_ACK; START outside IDLE is ignored.
// Ports: START/T_IN/Y_IN/H_IN request; BUSY status; f_bus to the derivative
// unit; K_1..K_4 results held until the next START, K_VALID one-cycle pulse.
module rk4_k_sequencer
  import rk4_k_sequencer_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     START,
  input  logic [N-1:0]             T_IN,
  input  logic [N-1:0]             Y_IN,
  input  logic [N-1:0]             H_IN,
  output logic                     BUSY,
  rk4_k_sequencer_if.master        f_bus,
  output logic [N-1:0]             K_1,
  output logic [N-1:0]             K_2,
  output logic [N-1:0]             K_3,
  output logic [N-1:0]             K_4,
  output logic                     K_VALID
);

  state_e       state_q, state_d;
  logic [1:0]   stage_q;
  logic [N-1:0] t_q, y_q, h_q;
  logic [N-1:0] f_cap_q;
  logic [N-1:0] k1_q, k2_q, k3_q, k4_q;

  logic [N-1:0] h_half, k1_half, k2_half;
  logic [N-1:0] ft_w, fy_w;
  logic [N-1:0] prod_w;
  logic         f_hs;

  // Arithmetic shift right by one.
  assign h_half  = {h_q[N-1],  h_q[N-1:1]};
  assign k1_half = {k1_q[N-1], k1_q[N-1:1]};
  assign k2_half = {k2_q[N-1], k2_q[N-1:1]};

  // f arguments depend only on registered state, so they stay put for the
  // whole REQ phase however long the ACK takes.
  always_comb begin
    ft_w = t_q;
    fy_w = y_q;
    case (stage_q)
      2'd0: begin ft_w = t_q;          fy_w = y_q;           end
      2'd1: begin ft_w = t_q + h_half; fy_w = y_q + k1_half; end
      2'd2: begin ft_w = t_q + h_half; fy_w = y_q + k2_half; end
      2'd3: begin ft_w = t_q + h_q;    fy_w = y_q + k3_q;    end
      default: ;
    endcase
  end

  // One multiplier serves all four stages; its result is only used in CALC.
  rk4_k_sequencer_fx_mul_q #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mul (
    .a_i (h_q),
    .b_i (f_cap_q),
    .p_o (prod_w)
  );

  assign f_hs = (state_q == S_REQ) && f_bus.F_ACK;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_REQ;
      S_REQ:  if (f_bus.F_ACK) state_d = S_CALC;
      S_CALC: state_d = (stage_q == 2'd3) ? S_DONE : S_REQ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      t_q     <= '0;
      y_q     <= '0;
      h_q     <= '0;
      f_cap_q <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      k4_q    <= '0;
    end else begin
      if ((state_q == S_IDLE) && START) begin
        t_q     <= T_IN;
        y_q     <= Y_IN;
        h_q     <= H_IN;
        stage_q <= '0;
      end
      if (f_hs) begin
        f_cap_q <= f_bus.F_VAL;
      end
      if (state_q == S_CALC) begin
        case (stage_q)
          2'd0: k1_q <= prod_w;
          2'd1: k2_q <= prod_w;
          2'd2: k3_q <= prod_w;
          2'd3: k4_q <= prod_w;
          default: ;
        endcase
        // Stage stays at 3 through DONE; the next START clears it.
        if (stage_q != 2'd3) begin
          stage_q <= stage_q + 2'd1;
        end
      end
    end
  end

  assign BUSY        = (state_q != S_IDLE);
  assign K_VALID     = (state_q == S_DONE);
  assign f_bus.F_REQ = (state_q == S_REQ);
  assign f_bus.F_T   = ft_w;
  assign f_bus.F_Y   = fy_w;
  assign K_1         = k1_q;
  assign K_2         = k2_q;
  assign K_3         = k3_q;
  assign K_4         = k4_q;

endmodule

// File: tb/tb_rk4_k_sequencer.sv
module tb_rk4_k_sequencer;
  import rk4_k_sequencer_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        START = 1'b0;
  logic [31:0] T_IN  = '0;
  logic [31:0] Y_IN  = '0;
  logic [31:0] H_IN  = '0;
  logic        BUSY;
  logic        K_VALID;
  logic [31:0] K_1, K_2, K_3, K_4;

  rk4_k_sequencer_if #(.N(32)) f_bus ();

  rk4_k_sequencer #(.N(32), .FRAC(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .START   (START),
    .T_IN    (T_IN),
    .Y_IN    (Y_IN),
    .H_IN    (H_IN),
    .BUSY    (BUSY),
    .f_bus   (f_bus),
    .K_1     (K_1),
    .K_2     (K_2),
    .K_3     (K_3),
    .K_4     (K_4),
    .K_VALID (K_VALID)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model outputs for the step in flight.
  logic [31:0] exp_ft[4];
  logic [31:0] exp_fy[4];
  logic [31:0] exp_k[4];
  int          exp_waits;
  bit          run_active = 1'b0;
  int          kv_pulses;

  logic [31:0] k_dut[4];
  always_comb begin
    k_dut[0] = K_1;
    k_dut[1] = K_2;
    k_dut[2] = K_3;
    k_dut[3] = K_4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Real-number meaning: a*b with Q16.16 operands, floored to a multiple of 2^-16.
  function automatic logic [31:0] fxm(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 16;
    return p[31:0];
  endfunction

  function automatic logic [31:0] hlf(input logic [31:0] x);
    int v;
    v = $signed(x);
    v = v >>> 1;
    return v;
  endfunction

  function automatic logic [31:0] f_of(input int mode, input logic [31:0] c, input logic [31:0] y);
    return (mode == 0) ? y : c;
  endfunction

  // Textbook RK4 slope sequence.
  task automatic model(input logic [31:0] t, input logic [31:0] y, input logic [31:0] h,
                       input int mode, input logic [31:0] c);
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin exp_ft[s] = t;          exp_fy[s] = y;                 end
        1: begin exp_ft[s] = t + hlf(h); exp_fy[s] = y + hlf(exp_k[0]); end
        2: begin exp_ft[s] = t + hlf(h); exp_fy[s] = y + hlf(exp_k[1]); end
        default: begin exp_ft[s] = t + h; exp_fy[s] = y + exp_k[2];     end
      endcase
      exp_k[s] = fxm(h, f_of(mode, c, exp_fy[s]));
    end
  endtask

  // Compare process: checks the DUT against the model every cycle of a step.
  int cyc;
  int acks;
  bit last_hs;
  bit last_kv;
  always @(negedge clk) begin
    if (!rst_n || !run_active) begin
      last_hs = 1'b0;
      last_kv = 1'b0;
    end else begin
      if (START && !BUSY) begin
        cyc  = 0;
        acks = 0;
      end else begin
        cyc++;
      end
      if (last_hs) chk("freq_drop_after_ack", f_bus.F_REQ, 0);
      if (f_bus.F_REQ) begin
        chk("busy_in_req", BUSY, 1);
        if (acks < 4) begin
          chk($sformatf("f_t_stage%0d", acks), f_bus.F_T, exp_ft[acks]);
          chk($sformatf("f_y_stage%0d", acks), f_bus.F_Y, exp_fy[acks]);
          for (int j = 0; j < acks; j++)
            chk($sformatf("k%0d_held_stage%0d", j + 1, acks), k_dut[j], exp_k[j]);
        end else begin
          timeout("extra_f_req");
        end
      end
      if (K_VALID) begin
        chk("kvalid_cycle", cyc, 9 + exp_waits);
        for (int j = 0; j < 4; j++)
          chk($sformatf("k%0d_at_valid", j + 1), k_dut[j], exp_k[j]);
        kv_pulses++;
      end
      if (last_kv) begin
        chk("kvalid_one_cycle", K_VALID, 0);
        chk("idle_after_done", BUSY, 0);
      end
      last_hs = f_bus.F_REQ && f_bus.F_ACK;
      if (last_hs) acks++;
      last_kv = K_VALID;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   BUSY, 0);
    chk({tag, "_freq"},   f_bus.F_REQ, 0);
    chk({tag, "_kvalid"}, K_VALID, 0);
    chk({tag, "_ft"},     f_bus.F_T, 0);
    chk({tag, "_fy"},     f_bus.F_Y, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("%s_k%0d", tag, j + 1), k_dut[j], 0);
  endtask

  // Acts as the f unit. wN = ACK wait cycles for stage N; glitch pulses START
  // in the first wait cycle of stage 2; abort_s >= 0 resets during that stage.
  task automatic run_step(input logic [31:0] t, input logic [31:0] y, input logic [31:0] h,
                          input int mode, input logic [31:0] c,
                          input int w0, input int w1, input int w2, input int w3,
                          input bit glitch, input int abort_s);
    int w[4];
    int n;
    w = '{w0, w1, w2, w3};
    model(t, y, h, mode, c);
    exp_waits = w0 + w1 + w2 + w3;
    kv_pulses = 0;
    @(posedge clk); #1;
    run_active = 1'b1;
    START = 1'b1; T_IN = t; Y_IN = y; H_IN = h;
    @(posedge clk); #1;
    START = 1'b0; T_IN = 32'hDEAD_BEEF; Y_IN = 32'h1234_5678; H_IN = 32'h7777_0000;
    for (int s = 0; s < 4; s++) begin
      n = 0;
      while (f_bus.F_REQ !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      if (n >= 64) begin timeout("wait_f_req"); run_active = 1'b0; return; end
      if (s == abort_s) begin
        #2;
        run_active = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      for (int i = 0; i < w[s]; i++) begin
        if (glitch && s == 2 && i == 0) START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
      end
      f_bus.F_ACK = 1'b1;
      f_bus.F_VAL = (mode == 0) ? f_bus.F_Y : c;
      @(posedge clk); #1;
      f_bus.F_ACK = 1'b0;
      f_bus.F_VAL = 32'h5A5A_5A5A;
    end
    n = 0;
    while (K_VALID !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) timeout("wait_k_valid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("kvalid_pulse_count", kv_pulses, 1);
    run_active = 1'b0;
  endtask

  task automatic chk_exp_k(input string tag);
    chk({tag, "_k1"}, K_1, 32'h0000_8000);
    chk({tag, "_k2"}, K_2, 32'h0000_A000);
    chk({tag, "_k3"}, K_3, 32'h0000_A800);
    chk({tag, "_k4"}, K_4, 32'h0000_D400);
  endtask

  initial begin
    f_bus.F_ACK = 1'b0;
    f_bus.F_VAL = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Exponential f=y, zero-wait ACK; also pins the model to hand values.
    run_step(32'h0, ONE, HALF, 0, 32'h0, 0, 0, 0, 0, 1'b0, -1);
    chk("model_ft1", exp_ft[1], 32'h0000_4000);
    chk("model_ft3", exp_ft[3], 32'h0000_8000);
    chk("model_fy1", exp_fy[1], 32'h0001_4000);
    chk("model_fy2", exp_fy[2], 32'h0001_5000);
    chk("model_fy3", exp_fy[3], 32'h0001_A800);
    chk("model_k4",  exp_k[3],  32'h0000_D400);
    chk_exp_k("exp_zero_wait");

    // Constant f = -2.0, h = 0.5.
    run_step(32'h0, ONE, HALF, 1, 32'hFFFE_0000, 0, 0, 0, 0, 1'b0, -1);
    for (int j = 0; j < 4; j++) chk($sformatf("const_k%0d", j + 1), k_dut[j], 32'hFFFF_0000);

    // Truncation toward -inf with the smallest h.
    run_step(32'h0, ONE, 32'h1, 1, 32'h0000_8000, 0, 0, 0, 0, 1'b0, -1);
    for (int j = 0; j < 4; j++) chk($sformatf("trunc_pos_k%0d", j + 1), k_dut[j], 32'h0000_0000);
    run_step(32'h0, ONE, 32'h1, 1, 32'hFFFF_8000, 0, 0, 0, 0, 1'b0, -1);
    for (int j = 0; j < 4; j++) chk($sformatf("trunc_neg_k%0d", j + 1), k_dut[j], 32'hFFFF_FFFF);

    // Random ACK delays.
    for (int r = 0; r < 3; r++) begin
      run_step(32'h0, ONE, HALF, 0, 32'h0,
               $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, -1);
      chk_exp_k($sformatf("exp_rand%0d", r));
    end

    // START pulsed during stage 2 with junk on the inputs.
    run_step(32'h0, ONE, HALF, 0, 32'h0, 0, 0, 2, 0, 1'b1, -1);
    chk_exp_k("exp_glitch");

    // Spurious F_ACK while idle.
    @(posedge clk); #1;
    f_bus.F_ACK = 1'b1;
    f_bus.F_VAL = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack_busy", BUSY, 0);
      chk("idle_ack_freq", f_bus.F_REQ, 0);
      chk("idle_ack_k1", K_1, 32'h0000_8000);
    end
    @(posedge clk); #1;
    f_bus.F_ACK = 1'b0;
    run_step(32'h0, ONE, HALF, 0, 32'h0, 1, 0, 0, 0, 1'b0, -1);
    chk_exp_k("exp_after_idle_ack");

    // Reset while waiting for the stage-1 ACK, then a full clean step.
    run_step(32'h0, ONE, HALF, 0, 32'h0, 0, 0, 0, 0, 1'b0, 1);
    run_step(32'h0, ONE, HALF, 0, 32'h0, 0, 0, 0, 0, 1'b0, -1);
    chk_exp_k("exp_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
